// File: rtl/fb_fill.sv
// Rectangle-fill engine owning the 1bpp framebuffer write port: merges host
// pixel-word writes with pattern fills of a word-aligned, clipped rectangle.
module fb_fill #(
    parameter int WORDS_PER_ROW = 20,
    parameter int ROWS          = 480,
    parameter int AW            = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          chipselect,
    input  logic          write,
    input  logic          read,
    input  logic [2:0]    address,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    input  logic          host_write,
    input  logic [AW-1:0] host_address,
    input  logic [31:0]   host_writedata,
    output logic          fb_write,
    output logic [AW-1:0] fb_address,
    output logic [31:0]   fb_writedata
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state, state_nx;

    logic [4:0]    x0_r, w_r;
    logic [8:0]    y0_r, h_r;
    logic [31:0]   pattern_r;

    logic [4:0]    x0_q, col, col_last;
    logic [8:0]    row_left;
    logic [AW-1:0] row_base;
    logic [31:0]   pat_q;
    logic [13:0]   count;
    logic          done;

    logic        reg_wr, reg_rd, start, abort, degenerate, engine_wr, last_word, busy;
    logic [5:0]  room_x;
    logic [9:0]  room_y;
    logic [4:0]  ew;
    logic [8:0]  eh;
    logic [31:0] rd_mux;

    assign reg_wr = chipselect & write;
    assign reg_rd = chipselect & read;
    assign start  = reg_wr && (address == 3'd5) && writedata[0];
    assign abort  = reg_wr && (address == 3'd5) && writedata[1];
    assign busy   = (state != IDLE);

    // Clip to the framebuffer edge; room_* are only meaningful when not degenerate.
    assign room_x     = 6'(WORDS_PER_ROW) - {1'b0, x0_r};
    assign room_y     = 10'(ROWS) - {1'b0, y0_r};
    assign ew         = ({1'b0, w_r} < room_x) ? w_r : room_x[4:0];
    assign eh         = ({1'b0, h_r} < room_y) ? h_r : room_y[8:0];
    assign degenerate = (x0_r >= 5'(WORDS_PER_ROW)) || (y0_r >= 9'(ROWS)) ||
                        (w_r == 5'd0) || (h_r == 9'd0);

    assign engine_wr = (state == RUN) && !host_write;
    assign last_word = (col == col_last) && (row_left == 9'd0);

    always_comb begin
        state_nx     = state;
        fb_write     = host_write;
        fb_address   = host_address;
        fb_writedata = host_writedata;
        case (state)
            IDLE: if (start && !abort) state_nx = degenerate ? FINISH : RUN;
            RUN: begin
                fb_write = 1'b1;
                if (!host_write) begin
                    fb_address   = row_base + AW'(col);
                    fb_writedata = pat_q;
                end
                if (abort)                      state_nx = IDLE;
                else if (engine_wr && last_word) state_nx = FINISH;
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd0: rd_mux = {27'd0, x0_r};
            3'd1: rd_mux = {23'd0, y0_r};
            3'd2: rd_mux = {27'd0, w_r};
            3'd3: rd_mux = {23'd0, h_r};
            3'd4: rd_mux = pattern_r;
            3'd5: rd_mux = {30'd0, done, busy};
            3'd6: rd_mux = {18'd0, count};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0_r      <= '0;
            y0_r      <= '0;
            w_r       <= '0;
            h_r       <= '0;
            pattern_r <= '0;
            readdata  <= '0;
            x0_q      <= '0;
            col       <= '0;
            col_last  <= '0;
            row_left  <= '0;
            row_base  <= '0;
            pat_q     <= '0;
            count     <= '0;
            done      <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (address)
                    3'd0: x0_r      <= writedata[4:0];
                    3'd1: y0_r      <= writedata[8:0];
                    3'd2: w_r       <= writedata[4:0];
                    3'd3: h_r       <= writedata[8:0];
                    3'd4: pattern_r <= writedata;
                    default: ;
                endcase
            end
            if (reg_rd) readdata <= rd_mux;

            if (state == IDLE && start && !abort) begin
                pat_q    <= pattern_r;
                x0_q     <= x0_r;
                col      <= x0_r;
                col_last <= x0_r + ew - 5'd1;
                row_left <= eh - 9'd1;
                // Y0*20 without a multiplier
                row_base <= AW'({y0_r, 4'b0000}) + AW'({y0_r, 2'b00});
                count    <= '0;
                done     <= 1'b0;
            end
            if (engine_wr) begin
                count <= count + 14'd1;
                if (col == col_last) begin
                    col      <= x0_q;
                    row_base <= row_base + AW'(WORDS_PER_ROW);
                    row_left <= row_left - 9'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end
            if (state == FINISH) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_fill.sv
// Randomized self-checking bench for fb_fill against a rectangle-list model.
module tb_fb_fill;
    logic        clk = 1'b0;
    logic        reset, chipselect, write, read;
    logic [2:0]  address;
    logic [31:0] writedata, readdata;
    logic        host_write;
    logic [14:0] host_address;
    logic [31:0] host_writedata;
    logic        fb_write;
    logic [14:0] fb_address;
    logic [31:0] fb_writedata;

    int checks = 0;
    int errors = 0;
    int exp_addr[$];

    always #10 clk = ~clk;

    fb_fill #(.WORDS_PER_ROW(20), .ROWS(480), .AW(15)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .host_write(host_write), .host_address(host_address), .host_writedata(host_writedata),
        .fb_write(fb_write), .fb_address(fb_address), .fb_writedata(fb_writedata)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        tick();
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Reference: list of word addresses a clipped rectangle covers, row-major.
    task automatic model_fill(input int x0, input int y0, input int w, input int h);
        int ew, eh;
        exp_addr.delete();
        if (x0 > 19 || y0 > 479 || w == 0 || h == 0) return;
        ew = (w < 20 - x0) ? w : 20 - x0;
        eh = (h < 480 - y0) ? h : 480 - y0;
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                exp_addr.push_back((y0 + r) * 20 + x0 + c);
    endtask

    task automatic run_fill(input string name, input int x0, input int y0, input int w,
                            input int h, input logic [31:0] pat, input int stall_pct,
                            input int stall_at);
        int idx, cyc, bad, first_idx;
        logic stall;
        logic [14:0] ea;
        logic [31:0] ed, d;
        logic [14:0] ba;
        logic [31:0] bd;
        logic bw;
        model_fill(x0, y0, w, h);
        reg_write(3'd0, 32'(x0));
        reg_write(3'd1, 32'(y0));
        reg_write(3'd2, 32'(w));
        reg_write(3'd3, 32'(h));
        reg_write(3'd4, pat);
        reg_write(3'd5, 32'd1);
        idx = 0; cyc = 0; bad = 0; first_idx = 0; ba = '0; bd = '0; bw = 1'b0;
        while (idx < exp_addr.size()) begin
            cyc++;
            stall = (cyc == stall_at) || (int'($urandom_range(0, 99)) < stall_pct);
            host_write     = stall;
            host_address   = (cyc == stall_at) ? 15'd7 : 15'($urandom_range(0, 9599));
            host_writedata = (cyc == stall_at) ? 32'hFFFF_FFFF : $urandom;
            @(negedge clk);
            ea = stall ? host_address : 15'(exp_addr[idx]);
            ed = stall ? host_writedata : pat;
            if (fb_write !== 1'b1 || fb_address !== ea || fb_writedata !== ed) begin
                if (bad == 0) begin
                    first_idx = cyc; bw = fb_write; ba = fb_address; bd = fb_writedata;
                end
                bad++;
            end
            if (!stall) idx++;
            tick();
            host_write = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s write_seq: %0d bad cycles, first at cycle %0d got w=%0b a=%0d d=%h",
                     name, bad, first_idx, bw, ba, bd);
        end
        // FINISH cycle: bus is host passthrough, status busy & not done
        chipselect = 1'b1; read = 1'b1; address = 3'd5;
        @(negedge clk);
        checks++;
        if (fb_write !== 1'b0) begin
            errors++;
            $display("FAIL %s finish_bus: fb_write=%0b want 0", name, fb_write);
        end
        tick();
        chipselect = 1'b0; read = 1'b0;
        checks++;
        if (readdata !== 32'd1) begin
            errors++;
            $display("FAIL %s finish_status: got %h want 1", name, readdata);
        end
        reg_read(3'd5, d);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL %s done_status: got %h want 2", name, d);
        end
        reg_read(3'd6, d);
        checks++;
        if (d !== 32'(exp_addr.size())) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", name, d, exp_addr.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; chipselect = 0; write = 0; read = 0; address = 0; writedata = 0;
        host_write = 0; host_address = 0; host_writedata = 0;
        repeat (3) tick();
        host_write = 1'b1; host_address = 15'd321; host_writedata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd321 || fb_writedata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_passthru: got w=%0b a=%0d d=%h", fb_write, fb_address, fb_writedata);
        end
        tick();
        host_write = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            reg_read(3'(i), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want 0", i, d);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        reg_write(3'd0, 0); reg_write(3'd1, 0); reg_write(3'd2, 20); reg_write(3'd3, 480);
        reg_write(3'd4, 32'h1234_5678);
        reg_write(3'd5, 32'd1);
        repeat (9) tick();
        reg_write(3'd5, 32'd2);
        @(negedge clk);
        checks++;
        if (fb_write !== 1'b0) begin
            errors++;
            $display("FAIL abort_bus: fb_write=%0b want 0", fb_write);
        end
        tick();
        reg_read(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL abort_status: got %h want 0", d);
        end
        reg_read(3'd6, d);
        checks++;
        if (d !== 32'd10) begin
            errors++;
            $display("FAIL abort_count: got %0d want 10", d);
        end
        // start and abort together: abort wins, nothing launches
        reg_write(3'd5, 32'd3);
        @(negedge clk);
        checks++;
        if (fb_write !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_bus: fb_write=%0b want 0", fb_write);
        end
        tick();
        reg_read(3'd5, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL start_abort_status: got %h want 0", d);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 14; n++) begin
            int x0, y0, w, h;
            x0 = int'($urandom_range(0, 21));
            y0 = (n % 2 == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(470, 485));
            w  = int'($urandom_range(0, 31));
            h  = int'($urandom_range(0, 12));
            run_fill($sformatf("rand%0d", n), x0, y0, w, h, $urandom, 25, -1);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d;
        reg_write(3'd0, 1); reg_write(3'd1, 2); reg_write(3'd2, 3); reg_write(3'd3, 100);
        reg_write(3'd4, 32'hCAFE_F00D);
        reg_write(3'd5, 32'd1);
        repeat (20) tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (fb_write !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle_bus: fb_write=%0b want 0", fb_write);
        end
        tick();
        reset = 1'b0;
        host_write = 1'b1; host_address = 15'd4444; host_writedata = 32'h0F0F_0F0F;
        @(negedge clk);
        checks++;
        if (fb_write !== 1'b1 || fb_address !== 15'd4444 || fb_writedata !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL midreset_passthru: got w=%0b a=%0d d=%h", fb_write, fb_address, fb_writedata);
        end
        tick();
        host_write = 1'b0;
        @(negedge clk);
        checks++;
        if (fb_write !== 1'b0) begin
            errors++;
            $display("FAIL midreset_dropped: fb_write=%0b want 0", fb_write);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            reg_read(3'(i), d);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL midreset_reg%0d: got %h want 0", i, d);
            end
        end
    endtask

    initial begin
        test_reset();
        run_fill("full_clear", 0, 0, 20, 480, 32'h0, 0, -1);
        run_fill("small_rect", 3, 5, 2, 2, 32'hA5A5_A5A5, 0, -1);
        run_fill("clipping", 18, 478, 5, 4, 32'h5A5A_0001, 0, -1);
        run_fill("host_stall", 3, 5, 2, 2, 32'hA5A5_A5A5, 0, 2);
        test_abort();
        run_fill("zero_width", 4, 4, 0, 7, 32'h1, 0, -1);
        run_fill("x0_out", 20, 4, 3, 3, 32'h2, 0, -1);
        test_random();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_fill.md
# fb_fill

Rectangle-fill engine for the 1-bit-per-pixel 640x480 VGA framebuffer. It owns the framebuffer write port: it merges direct CPU pixel-word writes with hardware fills of a word-aligned rectangle using a 32-bit pattern. It sits between the Avalon bus and the display peripheral's `write` / `address` / `writedata` inputs. Framebuffer layout is fixed: row r, pixel column c maps to word `r*20 + c/32`, bit `c%32`, and bit = 1 is white.

## Interface
- `WORDS_PER_ROW`, default 20: framebuffer words per scanline.
- `ROWS`, default 480: scanlines.
- `AW`, default 15: framebuffer word-address width.
- `clk` in 1: single clock, 50 MHz.
- `reset` in 1: asynchronous, active-high; clears all state.
- `chipselect` in 1: register-port select.
- `write` in 1: register write strobe, qualified by `chipselect`.
- `read` in 1: register read strobe, qualified by `chipselect`.
- `address` in 3: register index.
- `writedata` in 32: register write data.
- `readdata` out 32: register read data, registered, read latency 1.
- `host_write` in 1: CPU framebuffer word write.
- `host_address` in AW: CPU framebuffer word address.
- `host_writedata` in 32: CPU framebuffer data.
- `fb_write` out 1: framebuffer write strobe.
- `fb_address` out AW: framebuffer word address.
- `fb_writedata` out 32: framebuffer data.

## Operation
- **Registers** (writable at any time; the engine latches them at start):
  - 0 X0[4:0]: first word column.
  - 1 Y0[8:0]: first row.
  - 2 W[4:0]: width in words.
  - 3 H[8:0]: height in rows.
  - 4 PATTERN[31:0]: fill pattern.
  - 5 CTRL: write bit0 = start, bit1 = abort. Read returns STATUS: bit0 busy, bit1 done.
  - 6 COUNT[13:0]: read-only; words written by the current or last fill.
  - Unused bits and register 7 read as 0.
- **FSM states:** IDLE, RUN, FINISH.
- **IDLE -> RUN** on a start write.
  - Latch effective width `EW = min(W, 20-X0)` and effective height `EH = min(H, 480-Y0)`.
  - Set `row_base = Y0*20`, computed as `(Y0<<4)+(Y0<<2)`. No multiplier.
  - Set col = X0, COUNT = 0, clear done.
- **IDLE -> FINISH** on start if X0 > 19, Y0 > 479, W = 0 or H = 0. No framebuffer writes occur.
- **RUN, each cycle without a host write:**
  - Drive `fb_write = 1`, `fb_address = row_base + col`, `fb_writedata` = latched pattern. Increment COUNT.
  - Advance col. At the end of a row, set col = X0 and `row_base += 20`.
  - After the EW*EH-th write, go to FINISH.
- **RUN, cycle with `host_write = 1`:** the host wins. Drive `fb_*` = `host_*`. The engine holds col, row_base and COUNT and resumes the next cycle.
- **FINISH -> IDLE** after one cycle, with done = 1.
- **Outside RUN:** `fb_*` passes `host_*` through combinationally. `fb_write = host_write`.
- **Start ignored:** a start while busy (RUN or FINISH) is ignored.
- **Abort:** in RUN, abort goes to IDLE next cycle with done = 0. The partial COUNT is kept. An abort outside RUN has no effect. If start and abort are written together, abort wins.
- **busy** = state != IDLE.
- **Arithmetic:** addresses are AW bits and are never out of range after clipping. The maximum address is 9599.

## Timing
- **Reset values:** all registers 0, state IDLE, busy = 0, done = 0, COUNT = 0, `readdata` = 0, `fb_write` = `host_write`.
- **Start latency:** a start written in cycle N gives busy = 1 and the first engine `fb_write` in cycle N+1.
- **Fill duration:** an unstalled fill of EW*EH words occupies cycles N+1 .. N+EW*EH. FINISH is cycle N+EW*EH+1. Done = 1 and busy = 0 are visible from cycle N+EW*EH+2.
- **Stalls:** each host write during RUN adds exactly one cycle.
- **Register reads:** `readdata` is valid the cycle after a read strobe and reflects state at the strobe cycle.
- **Reset mid-fill:** the FSM returns to IDLE immediately. Any remaining writes are dropped.

## Test plan
- **Full clear.** X0=0, Y0=0, W=20, H=480, PATTERN=0, start.
  - 9600 consecutive writes to addresses 0..9599, data 0.
  - busy falls 9602 cycles after start. COUNT = 9600.
- **Small rectangle.** X0=3, Y0=5, W=2, H=2, PATTERN=0xA5A5A5A5.
  - Writes in order to 103, 104, 123, 124. No other writes. Done = 1.
- **Clipping.** X0=18, W=5, Y0=478, H=4.
  - Writes only to 9578, 9579, 9598, 9599. COUNT = 4.
- **Host stall.** During the small-rectangle fill, pulse `host_write` (address 7, data 0xFFFFFFFF) in the second RUN cycle.
  - That cycle carries the host write (addr 7).
  - The engine's 104 write moves one cycle later. Total RUN cycles = 5.
- **Abort and zero width.**
  - Abort in the 10th RUN cycle of the full clear: IDLE next cycle, done = 0, COUNT = 9 or 10 depending on that cycle's write.
  - Start with W=0: no writes, done = 1 two cycles later.
- **Reset mid-fill.** Assert `reset` mid-fill.
  - `fb_write` follows only `host_write`, busy = 0, and all registers read 0.
